alu_op_sequencer: RTL and testbench

- Next-generation ALU control: decodes RV32I ALU/branch ops plus RV32M (MUL/DIV/REM) into a 5-bit ALU operation code.
- Registered, valid/ready handshaked stage between decode and execute.
- Sequences multi-cycle M ops with a latency counter, stalling upstream until completion; supports flush.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_op_sequencer_decode.sv | 66 ++++++
 rtl/alu_op_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU op sequencer: operation codes, aluop classes, FSM states.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_AND    = 5'b00000,
        OP_OR     = 5'b00001,
        OP_ADD    = 5'b00010,
        OP_EQ     = 5'b00011,
        OP_SLL    = 5'b00100,
        OP_SRL    = 5'b00101,
        OP_SRA    = 5'b00111,
        OP_XOR    = 5'b01000,
        OP_SUB    = 5'b01010,
        OP_GE     = 5'b01100,
        OP_GEU    = 5'b01101,
        OP_SLT    = 5'b01110,
        OP_SLTU   = 5'b01111,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } alu_op_t;

    // Upstream aluop_i classes
    localparam logic [1:0] CLS_ADD    = 2'b00;
    localparam logic [1:0] CLS_BRANCH = 2'b01;
    localparam logic [1:0] CLS_ARITH  = 2'b10;
    localparam logic [1:0] CLS_RSVD   = 2'b11;

    // func7 value that selects the RV32M group
    localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

    // DONE is not a separate state: it is IDLE with valid_o held.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_decode.sv
// Pure combinational decode of aluop/func3/func7 into an ALU op code.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic       is_immediate,
    input  logic [1:0] aluop,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output logic [4:0] code,
    output logic       illegal,
    output logic       is_m
);

    // Decode: ADD/legal/non-M is the default, each class overrides.
    always_comb begin
        code    = OP_ADD;
        illegal = 1'b0;
        is_m    = 1'b0;
        case (aluop)
            CLS_ADD: code = OP_ADD;
            CLS_BRANCH: begin
                case (func3)
                    3'b000:  code = OP_SUB;
                    3'b001:  code = OP_EQ;
                    3'b100:  code = OP_GE;
                    3'b101:  code = OP_SLT;
                    3'b110:  code = OP_GEU;
                    3'b111:  code = OP_SLTU;
                    default: begin
                        code    = OP_SUB;
                        illegal = 1'b1;
                    end
                endcase
            end
            CLS_ARITH: begin
                if (!is_immediate && func7 == FUNC7_MULDIV) begin
                    if (ENABLE_M) begin
                        code = {2'b10, func3};
                        is_m = 1'b1;
                    end else begin
                        code    = OP_ADD;
                        illegal = 1'b1;
                    end
                end else begin
                    case (func3)
                        3'b000:  code = (!is_immediate && func7[5]) ? OP_SUB : OP_ADD;
                        3'b001:  code = OP_SLL;
                        3'b010:  code = OP_SLT;
                        3'b011:  code = OP_SLTU;
                        3'b100:  code = OP_XOR;
                        3'b101:  code = func7[5] ? OP_SRA : OP_SRL;
                        3'b110:  code = OP_OR;
                        default: code = OP_AND;
                    endcase
                end
            end
            default: begin
                code    = OP_ADD;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered decode->execute stage; multi-cycle M ops are held in WAIT for
// their latency while upstream is stalled, then presented like any other op.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter bit ENABLE_M    = 1'b1,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_LATENCY = 33,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic       is_immediate_i,
    input  logic [1:0] aluop_i,
    input  logic [2:0] func3_i,
    input  logic [6:0] func7_i,
    input  logic       flush_i,
    output logic       valid_o,
    input  logic       ready_i,
    output logic [4:0] aluop_o,
    output logic       illegal_o,
    output logic       mdu_start_o,
    output logic       mdu_kill_o,
    output logic       busy_o
);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_d, illegal_d, start_d, kill_d, busy_d;
    logic [4:0]       aluop_d;

    logic [4:0]       dec_code;
    logic             dec_illegal, dec_is_m;

    alu_op_decode #(.ENABLE_M(ENABLE_M)) u_decode (
        .is_immediate (is_immediate_i),
        .aluop        (aluop_i),
        .func3        (func3_i),
        .func7        (func7_i),
        .code         (dec_code),
        .illegal      (dec_illegal),
        .is_m         (dec_is_m)
    );

    // Next-state and handshake logic; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = valid_o;
        aluop_d   = aluop_o;
        illegal_d = illegal_o;
        busy_d    = busy_o;
        start_d   = 1'b0;
        kill_d    = 1'b0;
        ready_o   = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            kill_d  = (state_q == WAIT);
        end else begin
            case (state_q)
                IDLE: begin
                    ready_o = !valid_o || ready_i;
                    if (valid_o && ready_i)
                        valid_d = 1'b0;
                    if (valid_i && ready_o) begin
                        aluop_d   = dec_code;
                        illegal_d = dec_illegal;
                        if (dec_is_m) begin
                            start_d = 1'b1;
                            busy_d  = 1'b1;
                            cnt_d   = func3_i[2] ? CNT_W'(DIV_LATENCY) : CNT_W'(MUL_LATENCY);
                            state_d = WAIT;
                        end else begin
                            valid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    // Result becomes visible the cycle after the counter hits 1
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            valid_o     <= 1'b0;
            aluop_o     <= OP_ADD;
            illegal_o   <= 1'b0;
            mdu_start_o <= 1'b0;
            mdu_kill_o  <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_o     <= valid_d;
            aluop_o     <= aluop_d;
            illegal_o   <= illegal_d;
            mdu_start_o <= start_d;
            mdu_kill_o  <= kill_d;
            busy_o      <= busy_d;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: decode table, multi-cycle corner sequences and
// a randomized run against a cycle-numbered transaction model.
module tb_alu_op_sequencer;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 33;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_i, is_immediate_i, flush_i, ready_i;
    logic [1:0] aluop_i;
    logic [2:0] func3_i;
    logic [6:0] func7_i;

    logic       ready_o, valid_o, illegal_o, mdu_start_o, mdu_kill_o, busy_o;
    logic [4:0] aluop_o;
    logic       nm_ready, nm_valid, nm_illegal, nm_start, nm_kill, nm_busy;
    logic [4:0] nm_aluop;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.ENABLE_M(1'b1), .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .is_immediate_i(is_immediate_i), .aluop_i(aluop_i), .func3_i(func3_i),
        .func7_i(func7_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
        .aluop_o(aluop_o), .illegal_o(illegal_o), .mdu_start_o(mdu_start_o),
        .mdu_kill_o(mdu_kill_o), .busy_o(busy_o)
    );

    alu_op_sequencer #(.ENABLE_M(1'b0), .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT), .CNT_W(6)) dut_nm (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(nm_ready),
        .is_immediate_i(is_immediate_i), .aluop_i(aluop_i), .func3_i(func3_i),
        .func7_i(func7_i), .flush_i(flush_i), .valid_o(nm_valid), .ready_i(ready_i),
        .aluop_o(nm_aluop), .illegal_o(nm_illegal), .mdu_start_o(nm_start),
        .mdu_kill_o(nm_kill), .busy_o(nm_busy)
    );

    typedef struct {
        logic [1:0] aluop;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       imm;
        logic [4:0] exp_code;
        logic       exp_ill;
    } vec_t;

    vec_t tbl[$];

    // Reference decode tables, indexed by func3
    logic [4:0] br_tab [8];
    logic [4:0] ar_tab [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] a, input logic [2:0] f3,
                         input logic [6:0] f7, input logic imm);
        valid_i = v; aluop_i = a; func3_i = f3; func7_i = f7; is_immediate_i = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_decode(input logic [1:0] a, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic imm, input bit en_m,
                                       output logic [4:0] code, output logic ill, output logic is_m);
        code = 5'b00010; ill = 1'b0; is_m = 1'b0;
        if (a == 2'b01) begin
            code = br_tab[f3];
            ill  = (f3 == 3'd2) || (f3 == 3'd3);
        end else if (a == 2'b10) begin
            if (!imm && f7 == 7'd1) begin
                if (en_m) begin code = 5'b10000 + 5'(f3); is_m = 1'b1; end
                else ill = 1'b1;
            end else begin
                code = ar_tab[f3];
                if (f3 == 3'd0 && !imm && f7[5]) code = 5'b01010;
                if (f3 == 3'd5 && f7[5])         code = 5'b00111;
            end
        end else if (a == 2'b11) begin
            ill = 1'b1;
        end
    endfunction

    // Transaction model for the random phase: a pending M op is tracked by
    // the absolute cycle number at which its result must appear.
    int   cyc;
    bit   pend;
    int   pend_due;
    logic m_valid, m_ill, m_start, m_kill;
    logic [4:0] m_op;

    initial begin
        int bad;
        logic [4:0] code;
        logic ill, is_m, exp_ready, n_start, n_kill;

        br_tab = '{5'b01010, 5'b00011, 5'b01010, 5'b01010, 5'b01100, 5'b01110, 5'b01101, 5'b01111};
        ar_tab = '{5'b00010, 5'b00100, 5'b01110, 5'b01111, 5'b01000, 5'b00101, 5'b00001, 5'b00000};

        tbl.push_back('{2'b10, 3'b000, 7'b0100000, 1'b0, 5'b01010, 1'b0});
        tbl.push_back('{2'b10, 3'b000, 7'b0100000, 1'b1, 5'b00010, 1'b0});
        tbl.push_back('{2'b01, 3'b000, 7'b0000000, 1'b0, 5'b01010, 1'b0});
        tbl.push_back('{2'b01, 3'b001, 7'b0000000, 1'b0, 5'b00011, 1'b0});
        tbl.push_back('{2'b01, 3'b100, 7'b0000000, 1'b0, 5'b01100, 1'b0});
        tbl.push_back('{2'b01, 3'b101, 7'b0000000, 1'b0, 5'b01110, 1'b0});
        tbl.push_back('{2'b01, 3'b110, 7'b0000000, 1'b0, 5'b01101, 1'b0});
        tbl.push_back('{2'b01, 3'b111, 7'b0000000, 1'b0, 5'b01111, 1'b0});
        tbl.push_back('{2'b01, 3'b010, 7'b0000000, 1'b0, 5'b01010, 1'b1});
        tbl.push_back('{2'b01, 3'b011, 7'b0000000, 1'b0, 5'b01010, 1'b1});
        tbl.push_back('{2'b00, 3'b111, 7'b0100000, 1'b0, 5'b00010, 1'b0});
        tbl.push_back('{2'b11, 3'b000, 7'b0000000, 1'b0, 5'b00010, 1'b1});
        tbl.push_back('{2'b10, 3'b001, 7'b0000000, 1'b0, 5'b00100, 1'b0});
        tbl.push_back('{2'b10, 3'b010, 7'b0000000, 1'b0, 5'b01110, 1'b0});
        tbl.push_back('{2'b10, 3'b011, 7'b0000000, 1'b1, 5'b01111, 1'b0});
        tbl.push_back('{2'b10, 3'b100, 7'b0000000, 1'b0, 5'b01000, 1'b0});
        tbl.push_back('{2'b10, 3'b101, 7'b0000000, 1'b0, 5'b00101, 1'b0});
        tbl.push_back('{2'b10, 3'b101, 7'b0100000, 1'b1, 5'b00111, 1'b0});
        tbl.push_back('{2'b10, 3'b110, 7'b0000000, 1'b0, 5'b00001, 1'b0});
        tbl.push_back('{2'b10, 3'b111, 7'b0000000, 1'b0, 5'b00000, 1'b0});
        tbl.push_back('{2'b10, 3'b000, 7'b0000001, 1'b1, 5'b00010, 1'b0});

        // ---- reset with valid_i high ----
        rst_n = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
        drive(1'b1, 2'b00, 3'b000, 7'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_aluop", aluop_o, 5'b00010);
        chk("rst_illegal", illegal_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_start_kill", {mdu_start_o, mdu_kill_o}, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready_after", ready_o, 1);
        tick();
        chk("first_accept_valid", valid_o, 1);
        chk("first_accept_aluop", aluop_o, 5'b00010);

        // ---- decode table, back-to-back with ready_i=1 ----
        foreach (tbl[i]) begin
            drive(1'b1, tbl[i].aluop, tbl[i].f3, tbl[i].f7, tbl[i].imm);
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), ready_o, 1);
            tick();
            chk($sformatf("tbl%0d_valid", i), valid_o, 1);
            chk($sformatf("tbl%0d_aluop", i), aluop_o, tbl[i].exp_code);
            chk($sformatf("tbl%0d_illegal", i), illegal_o, tbl[i].exp_ill);
            chk($sformatf("tbl%0d_nm", i), {nm_valid, nm_aluop, nm_illegal}, {1'b1, tbl[i].exp_code, tbl[i].exp_ill});
        end
        drive(1'b0, 2'b00, 3'b000, 7'd0, 1'b0);
        tick();
        chk("drain_valid", valid_o, 0);

        // ---- DIVU full latency ----
        drive(1'b1, 2'b10, 3'b101, 7'b0000001, 1'b0);
        @(negedge clk);
        chk("divu_ready_accept", ready_o, 1);
        tick();
        valid_i = 1'b0;
        @(negedge clk);
        chk("divu_start", mdu_start_o, 1);
        chk("divu_busy", busy_o, 1);
        bad = 0;
        for (int k = 1; k <= DIV_LAT; k++) begin
            if (ready_o || valid_o || !busy_o) bad++;
            if (k > 1 && mdu_start_o) bad++;
            tick();
            @(negedge clk);
        end
        chk("divu_wait_cycles", bad, 0);
        chk("divu_valid", valid_o, 1);
        chk("divu_aluop", aluop_o, 5'b10101);
        chk("divu_busy_done", busy_o, 0);
        chk("divu_ready_done", ready_o, 1);
        tick();

        // ---- MUL flushed in first WAIT cycle ----
        drive(1'b1, 2'b10, 3'b000, 7'b0000001, 1'b0);
        @(negedge clk);
        tick();
        valid_i = 1'b0;
        flush_i = 1'b1;
        @(negedge clk);
        chk("mflush_ready_during", ready_o, 0);
        chk("mflush_start", mdu_start_o, 1);
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        chk("mflush_kill", mdu_kill_o, 1);
        chk("mflush_busy", busy_o, 0);
        chk("mflush_ready_after", ready_o, 1);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (valid_o) bad++;
            if (k > 0 && (mdu_kill_o || mdu_start_o)) bad++;
            tick();
            @(negedge clk);
        end
        chk("mflush_no_valid", bad, 0);

        // ---- hold under backpressure, then reload without bubble ----
        tick();
        drive(1'b1, 2'b10, 3'b100, 7'd0, 1'b0);
        @(negedge clk);
        tick();
        ready_i = 1'b0;
        drive(1'b1, 2'b10, 3'b001, 7'd0, 1'b0);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!valid_o || aluop_o !== 5'b01000 || ready_o) bad++;
            tick();
        end
        chk("hold_stable", bad, 0);
        ready_i = 1'b1;
        @(negedge clk);
        chk("hold_release_ready", ready_o, 1);
        tick();
        chk("reload_valid", valid_o, 1);
        chk("reload_aluop", aluop_o, 5'b00100);
        valid_i = 1'b0;
        repeat (2) tick();

        // ---- ENABLE_M=0: MUL encoding is ADD + illegal ----
        drive(1'b1, 2'b10, 3'b000, 7'b0000001, 1'b0);
        @(negedge clk);
        chk("nm_ready", nm_ready, 1);
        tick();
        valid_i = 1'b0;
        @(negedge clk);
        chk("nm_mul_op", {nm_valid, nm_aluop, nm_illegal}, {1'b1, 5'b00010, 1'b1});
        chk("nm_no_start", {nm_start, nm_busy}, 0);
        chk("m_mul_start", mdu_start_o, 1);
        repeat (5) tick();

        // ---- randomized run against the transaction model ----
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        cyc = 0; pend = 0; pend_due = 0;
        m_valid = 0; m_ill = 0; m_op = 5'b00010; m_start = 0; m_kill = 0;
        for (int n = 0; n < 3000; n++) begin
            logic [6:0] f7;
            case ($urandom_range(3))
                0: f7 = 7'd0;
                1: f7 = 7'b0100000;
                2: f7 = 7'b0000001;
                default: f7 = 7'($urandom);
            endcase
            drive($urandom_range(9) < 7, 2'($urandom), 3'($urandom), f7, 1'($urandom));
            ready_i = $urandom_range(9) < 7;
            flush_i = $urandom_range(24) == 0;
            @(negedge clk);
            exp_ready = !flush_i && !pend && (!m_valid || ready_i);
            chk("rnd_valid", valid_o, m_valid);
            chk("rnd_ready", ready_o, exp_ready);
            chk("rnd_busy", busy_o, pend);
            chk("rnd_start", mdu_start_o, m_start);
            chk("rnd_kill", mdu_kill_o, m_kill);
            if (m_valid) chk("rnd_op", {aluop_o, illegal_o}, {m_op, m_ill});
            n_start = 0; n_kill = 0;
            if (flush_i) begin
                n_kill = pend; pend = 0; m_valid = 0;
            end else if (pend) begin
                if (cyc + 1 == pend_due) begin m_valid = 1; pend = 0; end
            end else begin
                if (m_valid && ready_i) m_valid = 0;
                if (valid_i && exp_ready) begin
                    ref_decode(aluop_i, func3_i, func7_i, is_immediate_i, 1'b1, code, ill, is_m);
                    m_op = code; m_ill = ill;
                    if (is_m) begin
                        pend = 1; n_start = 1;
                        pend_due = cyc + 1 + (func3_i[2] ? DIV_LAT : MUL_LAT);
                    end else m_valid = 1;
                end
            end
            m_start = n_start; m_kill = n_kill;
            tick();
            cyc++;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
